tribus_arbiter: RTL and testbench

TRIBUS_ARBITER -- requirements
Module: tribus_arbiter

---
 rtl/tribus_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 32 +++
 rtl/tribus_arbiter.sv | 146 ++++++++++++++
 tb/tb_tribus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tribus_arb_pkg.sv
// Shared types and default sizing for the tristate bus arbiter.
// States and constants used by tribus_arbiter and rr_pick.
package tribus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int TURN_CYC_DEF = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Lowest rotational distance from ptr wins.
module rr_pick
  import tribus_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    // Scan farthest-first so the nearest hit overwrites.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[IW'(j)]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin arbiter for tristate bus drivers with hold limit and turnaround.
// Optional bus parking on the last owner: define TRIBUS_ARB_PARK_EN.
module tribus_arbiter
  import tribus_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF
) (
  input  logic                     CLK,
  input  logic                     RSTB,
  input  logic [N_REQ-1:0]         REQ,
  output logic [N_REQ-1:0]         ENB,
  output logic                     BUSY,
  output logic [$clog2(N_REQ)-1:0] OWNER
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] enb_q, enb_d;
  logic             busy_q, busy_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [2:0]       turn_q, turn_d;

  logic             win_vld;
  logic [IW-1:0]    win;
  logic [N_REQ-1:0] own_oh, win_oh;
  logic             others, hold_max;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .valid (win_vld),
    .idx   (win)
  );

  always_comb begin
    own_oh          = '0;
    own_oh[owner_q] = 1'b1;
    win_oh          = '0;
    win_oh[win]     = 1'b1;
    others          = |(REQ & ~own_oh);
    hold_max        = (hold_q == HW'(MAX_HOLD));
  end

  always_comb begin
    state_d = state_q;
    enb_d   = enb_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
`ifdef TRIBUS_ARB_PARK_EN
          // Parked owner reclaims the bus without a turnaround.
          if (|enb_q && REQ[owner_q]) begin
            state_d = GRANT;
            busy_d  = 1'b1;
            hold_d  = HW'(1);
          end else if (|enb_q) begin
            state_d = TURN;
            enb_d   = '0;
            turn_d  = 3'(TURN_CYC - 1);
          end else begin
            state_d = GRANT;
            enb_d   = win_oh;
            busy_d  = 1'b1;
            owner_d = win;
            hold_d  = HW'(1);
          end
`else
          state_d = GRANT;
          enb_d   = win_oh;
          busy_d  = 1'b1;
          owner_d = win;
          hold_d  = HW'(1);
`endif
        end
      end
      GRANT: begin
        if (!REQ[owner_q] || (hold_max && others)) begin
          state_d = TURN;
          enb_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          turn_d  = 3'(TURN_CYC - 1);
        end else begin
          hold_d = hold_max ? HW'(1) : hold_q + 1'b1;
        end
      end
      TURN: begin
        if (turn_q != 3'd0) begin
          turn_d = turn_q - 3'd1;
        end else if (win_vld) begin
          state_d = GRANT;
          enb_d   = win_oh;
          busy_d  = 1'b1;
          owner_d = win;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
`ifdef TRIBUS_ARB_PARK_EN
          enb_d   = own_oh;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        enb_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state_q <= IDLE;
      enb_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      enb_q   <= enb_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign ENB   = enb_q;
  assign BUSY  = busy_q;
  assign OWNER = owner_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Self-checking bench for tribus_arbiter: directed scenarios plus random
// traffic against a bus-ownership model; parking checks need TRIBUS_ARB_PARK_EN.
module tb_tribus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int TURN_CYC = 1;
`ifdef TRIBUS_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RSTB = 1'b0;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] ENB;
  logic         BUSY;
  logic [1:0]   OWNER;

  int checks = 0;
  int errors = 0;

  tribus_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MAX_HOLD),
    .TURN_CYC (TURN_CYC)
  ) u_dut (
    .CLK   (CLK),
    .RSTB  (RSTB),
    .REQ   (REQ),
    .ENB   (ENB),
    .BUSY  (BUSY),
    .OWNER (OWNER)
  );

  always #5 CLK = ~CLK;

  // Model: who owns the bus, how long, and how many quiet cycles remain.
  int m_own  = -1;
  int m_hold = 0;
  int m_gap  = 0;
  int m_ptr  = 0;
  int m_last = 0;
  bit m_park = 1'b0;

  function automatic int rr_first(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_enb();
    logic [N-1:0] e;
    e = '0;
    if (m_own >= 0) e[m_own] = 1'b1;
    else if (m_park) e[m_last] = 1'b1;
    return e;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic rst_b);
    int w;
    if (!rst_b) begin
      m_own = -1; m_hold = 0; m_gap = 0;
      m_ptr = 0; m_last = 0; m_park = 1'b0;
      return;
    end
    if (m_own >= 0) begin
      if (!r[m_own] ||
          (m_hold == MAX_HOLD && (int'(r) & ~(1 << m_own)) != 0)) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
        m_gap = TURN_CYC;
      end else begin
        m_hold = (m_hold == MAX_HOLD) ? 1 : m_hold + 1;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else if (m_gap == 0 && m_park && r != '0) begin
      if (r[m_last]) begin
        m_own  = m_last;
        m_hold = 1;
      end else begin
        m_park = 1'b0;
        m_gap  = TURN_CYC;
      end
    end else begin
      w = rr_first(r, m_ptr);
      if (w >= 0) begin
        m_own = w; m_hold = 1; m_last = w; m_park = 1'b0;
      end else if (m_gap == 1) begin
        m_park = PARK;
      end
      m_gap = 0;
    end
  endtask

  task automatic tick(input logic [N-1:0] r);
    REQ = r;
    @(posedge CLK);
    model_step(r, RSTB);
    #1;
  endtask

  task automatic do_reset();
    RSTB = 1'b0;
    tick('0);
    tick('0);
    RSTB = 1'b1;
  endtask

  // Every-cycle bus safety: one-hot-or-zero and turnaround gap.
  int           zero_run = 255;
  logic [N-1:0] prev_enb = '0;

  always @(negedge CLK) begin
    if (!RSTB) begin
      zero_run = 255;
      prev_enb = '0;
    end else begin
      checks++;
      if ($countones(ENB) > 1) begin
        errors++;
        $display("FAIL onehot: ENB=%b, required at most one bit", ENB);
      end
      if (ENB != '0 && prev_enb == '0 && zero_run < TURN_CYC) begin
        errors++;
        $display("FAIL turn_gap: %0d zero cycles before ENB=%b, required >= %0d",
                 zero_run, ENB, TURN_CYC);
      end
      if (ENB != '0 && prev_enb != '0 && ENB != prev_enb) begin
        errors++;
        $display("FAIL turn_gap: ENB %b -> %b with no gap", prev_enb, ENB);
      end
      if (ENB == '0) zero_run = (zero_run < 255) ? zero_run + 1 : 255;
      else zero_run = 0;
      prev_enb = ENB;
    end
  end

  task automatic test_reset();
    RSTB = 1'b0;
    tick(4'b1111);
    tick(4'b1111);
    checks++;
    if (ENB !== 4'b0000 || BUSY !== 1'b0 || OWNER !== 2'd0) begin
      errors++;
      $display("FAIL reset: ENB=%b BUSY=%b OWNER=%0d, required 0000/0/0",
               ENB, BUSY, OWNER);
    end
    RSTB = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    tick(4'b0001);
    checks++;
    if (ENB !== 4'b0001 || BUSY !== 1'b1 || OWNER !== 2'd0) begin
      errors++;
      $display("FAIL single_grant: ENB=%b BUSY=%b OWNER=%0d, required 0001/1/0",
               ENB, BUSY, OWNER);
    end
    for (int c = 2; c <= 5; c++) begin
      tick(c == 5 ? 4'b0000 : 4'b0001);
      checks++;
      if (c < 5 && ENB !== 4'b0001) begin
        errors++;
        $display("FAIL single_hold: cycle %0d ENB=%b, required 0001", c, ENB);
      end
      if (c == 5 && (ENB !== 4'b0000 || BUSY !== 1'b0 || OWNER !== 2'd0)) begin
        errors++;
        $display("FAIL single_release: ENB=%b BUSY=%b OWNER=%0d, required 0000/0/0",
                 ENB, BUSY, OWNER);
      end
    end
    tick('0);
  endtask

  task automatic test_rotation();
    logic [N-1:0] e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < MAX_HOLD; j++) begin
        tick(4'b1111);
        e = '0;
        e[k % N] = 1'b1;
        checks++;
        if (ENB !== e) begin
          errors++;
          $display("FAIL rotation: slot %0d cyc %0d ENB=%b, required %b",
                   k, j, ENB, e);
        end
      end
      if (k < 4) begin
        for (int g = 0; g < TURN_CYC; g++) begin
          tick(4'b1111);
          checks++;
          if (ENB !== 4'b0000) begin
            errors++;
            $display("FAIL rotation_gap: after slot %0d ENB=%b, required 0000",
                     k, ENB);
          end
        end
      end
    end
    tick('0);
    tick('0);
  endtask

  task automatic test_preempt();
    do_reset();
    for (int t = 1; t <= 20; t++) begin
      tick(4'b0100);
      checks++;
      if (ENB !== 4'b0100) begin
        errors++;
        $display("FAIL alone_hold: t=%0d ENB=%b, required 0100", t, ENB);
      end
    end
    tick('0);
    tick('0);
    tick('0);
    for (int t = 1; t <= 18; t++) begin
      tick(t <= 12 ? 4'b0100 : 4'b0101);
      checks++;
      if (t <= 16 && ENB !== 4'b0100) begin
        errors++;
        $display("FAIL preempt_hold: t=%0d ENB=%b, required 0100", t, ENB);
      end
      if (t == 17 && ENB !== 4'b0000) begin
        errors++;
        $display("FAIL preempt_turn: ENB=%b, required 0000", ENB);
      end
      if (t == 18 && ENB !== 4'b0001) begin
        errors++;
        $display("FAIL preempt_next: ENB=%b, required 0001", ENB);
      end
    end
    tick('0);
    tick('0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(4'b0100);
    tick(4'b0100);
    checks++;
    if (ENB !== 4'b0100 || OWNER !== 2'd2) begin
      errors++;
      $display("FAIL mid_setup: ENB=%b OWNER=%0d, required 0100/2", ENB, OWNER);
    end
    RSTB = 1'b0;
    tick(4'b0100);
    checks++;
    if (ENB !== 4'b0000 || BUSY !== 1'b0 || OWNER !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: ENB=%b BUSY=%b OWNER=%0d, required 0000/0/0",
               ENB, BUSY, OWNER);
    end
    RSTB = 1'b1;
    tick(4'b0100);
    checks++;
    if (ENB !== 4'b0100 || BUSY !== 1'b1 || OWNER !== 2'd2) begin
      errors++;
      $display("FAIL post_reset: ENB=%b BUSY=%b OWNER=%0d, required 0100/1/2",
               ENB, BUSY, OWNER);
    end
    tick('0);
    tick('0);
  endtask

`ifdef TRIBUS_ARB_PARK_EN
  task automatic test_park();
    do_reset();
    tick(4'b0010);
    tick(4'b0010);
    tick(4'b0000);
    checks++;
    if (ENB !== 4'b0000) begin
      errors++;
      $display("FAIL park_turn: ENB=%b, required 0000", ENB);
    end
    for (int g = 1; g < TURN_CYC; g++) tick('0);
    tick('0);
    checks++;
    if (ENB !== 4'b0010 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL parked: ENB=%b BUSY=%b, required 0010/0", ENB, BUSY);
    end
    tick(4'b0010);
    checks++;
    if (ENB !== 4'b0010 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL park_reclaim: ENB=%b BUSY=%b, required 0010/1", ENB, BUSY);
    end
    tick('0);
    for (int g = 1; g < TURN_CYC; g++) tick('0);
    tick('0);
    for (int g = 0; g < TURN_CYC; g++) begin
      tick(4'b1000);
      checks++;
      if (ENB !== 4'b0000) begin
        errors++;
        $display("FAIL park_switch_gap: ENB=%b, required 0000", ENB);
      end
    end
    tick(4'b1000);
    checks++;
    if (ENB !== 4'b1000 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL park_switch: ENB=%b BUSY=%b, required 1000/1", ENB, BUSY);
    end
    tick('0);
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      RSTB = ($urandom_range(0, 199) != 0);
      tick(r);
      checks++;
      if (ENB !== exp_enb() || BUSY !== (m_own >= 0) || OWNER !== 2'(m_last)) begin
        errors++;
        $display("FAIL random c=%0d REQ=%b: ENB=%b BUSY=%b OWNER=%0d, required %b/%0d/%0d",
                 c, r, ENB, BUSY, OWNER, exp_enb(), m_own >= 0, m_last);
      end
    end
    RSTB = 1'b1;
    tick('0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_preempt();
    test_reset_mid();
`ifdef TRIBUS_ARB_PARK_EN
    test_park();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
